// File: rtl/mem_arbiter_pkg.sv
// Shared widths, the starvation-limit default and the response FSM encoding
// for the instruction/data SRAM arbiter.
package mem_arbiter_pkg;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;
    localparam int CNT_W  = 4;

    localparam int unsigned DEFAULT_STARVE_LIMIT = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RESP_INST = 2'd1,
        RESP_DATA = 2'd2
    } resp_state_e;
endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, load/store port, shared SRAM command port and the
// pipeline stall request seen by the arbiter.
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    // Handshake: a requester holds *_req (and its address/data) high until it
    // sees *_gnt in the same cycle; read data comes back with *_rvalid exactly
    // one cycle after the grant, and stores never produce *_rvalid.
    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_gnt;
    logic              inst_rvalid;
    logic [DATA_W-1:0] inst_rdata;

    logic              data_req;
    logic [BE_W-1:0]   data_wen;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_gnt;
    logic              data_rvalid;
    logic [DATA_W-1:0] data_rdata;

    logic              sram_en;
    logic [BE_W-1:0]   sram_wen;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;

    logic              stallreq;

    modport slave (
        input  inst_req, inst_addr,
        output inst_gnt, inst_rvalid, inst_rdata,
        input  data_req, data_wen, data_addr, data_wdata,
        output data_gnt, data_rvalid, data_rdata,
        output sram_en, sram_wen, sram_addr, sram_wdata,
        input  sram_rdata,
        output stallreq
    );

    modport master (
        output inst_req, inst_addr,
        input  inst_gnt, inst_rvalid, inst_rdata,
        output data_req, data_wen, data_addr, data_wdata,
        input  data_gnt, data_rvalid, data_rdata,
        input  sram_en, sram_wen, sram_addr, sram_wdata,
        output sram_rdata,
        input  stallreq
    );
endinterface

// File: rtl/mem_arbiter_arb_prio.sv
// Combinational grant logic: data wins by default, instruction wins once it
// has been passed over STARVE_LIMIT consecutive times.
module mem_arbiter_arb_prio
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
    input  logic             enable,
    input  logic             inst_req,
    input  logic             data_req,
    input  logic [CNT_W-1:0] starve_cnt,
    output logic             inst_gnt,
    output logic             data_gnt,
    output logic [CNT_W-1:0] starve_nxt
);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic inst_starved;

    always_comb begin
        inst_starved = inst_req && (starve_cnt == LIMIT);
        data_gnt     = enable && data_req && !inst_starved;
        inst_gnt     = enable && inst_req && !data_gnt;

        // Count only data grants that overtake a waiting fetch.
        starve_nxt = starve_cnt;
        if (!inst_req || inst_gnt) begin
            starve_nxt = '0;
        end else if (data_gnt && (starve_cnt < LIMIT)) begin
            starve_nxt = starve_cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port SRAM between instruction fetch and load/store,
// returning read data to the winning requester one cycle after its grant.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = DEFAULT_STARVE_LIMIT  // legal 1..15
) (
    input  logic             clk,
    input  logic             rst,
    mem_arbiter_if.slave     bus,
    output resp_state_e      state_dbg,
    output logic [CNT_W-1:0] starve_cnt_dbg
);
    resp_state_e      state_q, state_d;
    logic [CNT_W-1:0] starve_q, starve_d;
    logic             inst_gnt, data_gnt;

    // Reset level gates the grants so nothing escapes while rst is low.
    mem_arbiter_arb_prio #(.STARVE_LIMIT(STARVE_LIMIT)) u_prio (
        .enable     (rst),
        .inst_req   (bus.inst_req),
        .data_req   (bus.data_req),
        .starve_cnt (starve_q),
        .inst_gnt   (inst_gnt),
        .data_gnt   (data_gnt),
        .starve_nxt (starve_d)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        state_d = IDLE;
        if (inst_gnt) begin
            state_d = RESP_INST;
        end else if (data_gnt && (bus.data_wen == '0)) begin
            state_d = RESP_DATA;
        end
    end

    always_comb begin
        bus.sram_en    = 1'b0;
        bus.sram_wen   = '0;
        bus.sram_addr  = '0;
        bus.sram_wdata = '0;
        if (data_gnt) begin
            bus.sram_en    = 1'b1;
            bus.sram_wen   = bus.data_wen;
            bus.sram_addr  = bus.data_addr;
            bus.sram_wdata = bus.data_wdata;
        end else if (inst_gnt) begin
            bus.sram_en   = 1'b1;
            bus.sram_addr = bus.inst_addr;
        end
    end

    assign bus.inst_gnt    = inst_gnt;
    assign bus.data_gnt    = data_gnt;
    assign bus.inst_rvalid = (state_q == RESP_INST);
    assign bus.data_rvalid = (state_q == RESP_DATA);
    assign bus.inst_rdata  = bus.inst_rvalid ? bus.sram_rdata : '0;
    assign bus.data_rdata  = bus.data_rvalid ? bus.sram_rdata : '0;

    assign bus.stallreq = rst && ((bus.inst_req && !inst_gnt)
                                  || (bus.data_req && !data_gnt)
                                  || ((state_q == RESP_DATA) && bus.data_req && !data_gnt));

    assign state_dbg      = state_q;
    assign starve_cnt_dbg = starve_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized
// run scored against a behavioural arbitration/response model.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int unsigned LIMIT = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if bus ();
    resp_state_e   state_dbg;
    logic [3:0]    starve_cnt_dbg;

    mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .state_dbg      (state_dbg),
        .starve_cnt_dbg (starve_cnt_dbg)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0]  ctl;
    logic [1:0]  rv;
    logic [67:0] sram_cmd;
    assign ctl      = {bus.inst_gnt, bus.data_gnt, bus.sram_en, bus.stallreq};
    assign rv       = {bus.inst_rvalid, bus.data_rvalid};
    assign sram_cmd = {bus.sram_wen, bus.sram_addr, bus.sram_wdata};

    // ROM contents of the shared SRAM, a pure function of address.
    function automatic logic [31:0] rom(input logic [31:0] a);
        return (a == 32'hBFC0_0000) ? 32'h2401_0001 : (a ^ 32'hA5C3_0F96);
    endfunction

    // SRAM model: read data appears one cycle after a read command.
    always @(posedge clk or negedge rst) begin
        if (!rst) bus.sram_rdata <= 32'hDEAD_BEEF;
        else if (bus.sram_en && (bus.sram_wen == 4'b0)) bus.sram_rdata <= rom(bus.sram_addr);
    end

    // ---------------- driver tasks ----------------
    task automatic set_req(input logic ireq, input logic [31:0] iaddr, input logic dreq,
                           input logic [3:0] dwen, input logic [31:0] daddr, input logic [31:0] dwdata);
        bus.inst_req   = ireq;
        bus.inst_addr  = iaddr;
        bus.data_req   = dreq;
        bus.data_wen   = dwen;
        bus.data_addr  = daddr;
        bus.data_wdata = dwdata;
    endtask

    task automatic drive_cycle(input logic ireq, input logic [31:0] iaddr, input logic dreq,
                               input logic [3:0] dwen, input logic [31:0] daddr, input logic [31:0] dwdata);
        @(negedge clk);
        set_req(ireq, iaddr, dreq, dwen, daddr, dwdata);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        set_req(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        set_req(1'b1, 32'h0000_1000, 1'b1, 4'hF, 32'h0000_2000, 32'h1234_5678);
        #1;
        n_cmp++; if (ctl !== 4'b0000) begin n_err++; $display("FAIL reset_ctl: got %b want 0000", ctl); end
        n_cmp++; if (rv !== 2'b00) begin n_err++; $display("FAIL reset_rvalid: got %b want 00", rv); end
        n_cmp++; if ({bus.inst_rdata, bus.data_rdata} !== 64'h0) begin n_err++; $display("FAIL reset_rdata: got %h %h want 0", bus.inst_rdata, bus.data_rdata); end
        n_cmp++; if (sram_cmd !== 68'h0) begin n_err++; $display("FAIL reset_sram: got %h want 0", sram_cmd); end
        @(negedge clk); #1;
        n_cmp++; if (ctl !== 4'b0000) begin n_err++; $display("FAIL reset_ctl_held: got %b want 0000", ctl); end
        n_cmp++; if (state_dbg !== IDLE) begin n_err++; $display("FAIL reset_state: got %0d want IDLE", state_dbg); end
        n_cmp++; if (starve_cnt_dbg !== 4'd0) begin n_err++; $display("FAIL reset_starve: got %0d want 0", starve_cnt_dbg); end
        // first grant on the first edge after release
        @(negedge clk);
        rst = 1'b1;
        set_req(1'b1, 32'hBFC0_0000, 1'b0, 4'h0, 32'h0, 32'h0);
        #1;
        n_cmp++; if (ctl !== 4'b1010) begin n_err++; $display("FAIL release_gnt: got %b want 1010", ctl); end
        drive_cycle(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        n_cmp++; if (rv !== 2'b10) begin n_err++; $display("FAIL release_rvalid: got %b want 10", rv); end
    endtask

    task automatic test_inst_fetch();
        do_reset();
        drive_cycle(1'b1, 32'hBFC0_0000, 1'b0, 4'hF, 32'h1111_2222, 32'h3333_4444);
        n_cmp++; if (ctl !== 4'b1010) begin n_err++; $display("FAIL fetch_ctl: got %b want 1010", ctl); end
        n_cmp++; if (sram_cmd !== {4'h0, 32'hBFC0_0000, 32'h0}) begin n_err++; $display("FAIL fetch_sram: got %h want %h", sram_cmd, {4'h0, 32'hBFC0_0000, 32'h0}); end
        drive_cycle(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        n_cmp++; if ({rv, bus.stallreq} !== 3'b100) begin n_err++; $display("FAIL fetch_rvalid: got %b want 100", {rv, bus.stallreq}); end
        n_cmp++; if (bus.inst_rdata !== 32'h2401_0001) begin n_err++; $display("FAIL fetch_rdata: got %h want 24010001", bus.inst_rdata); end
        n_cmp++; if (bus.data_rdata !== 32'h0) begin n_err++; $display("FAIL fetch_data_rdata: got %h want 0", bus.data_rdata); end
        drive_cycle(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        n_cmp++; if ({rv, bus.inst_rdata} !== 34'h0) begin n_err++; $display("FAIL fetch_after: got %b %h want 00 0", rv, bus.inst_rdata); end
    endtask

    task automatic test_conflict();
        do_reset();
        drive_cycle(1'b1, 32'hBFC0_0004, 1'b1, 4'h0, 32'h8000_0010, 32'h0);
        n_cmp++; if (ctl !== 4'b0111) begin n_err++; $display("FAIL conflict_ctl: got %b want 0111", ctl); end
        n_cmp++; if (bus.sram_addr !== 32'h8000_0010) begin n_err++; $display("FAIL conflict_addr: got %h want 80000010", bus.sram_addr); end
        drive_cycle(1'b1, 32'hBFC0_0004, 1'b0, 4'h0, 32'h0, 32'h0);
        n_cmp++; if (ctl !== 4'b1010) begin n_err++; $display("FAIL conflict_inst_ctl: got %b want 1010", ctl); end
        n_cmp++; if ({rv, bus.data_rdata} !== {2'b01, rom(32'h8000_0010)}) begin n_err++; $display("FAIL conflict_data_resp: got %b %h want 01 %h", rv, bus.data_rdata, rom(32'h8000_0010)); end
        drive_cycle(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        n_cmp++; if ({rv, bus.inst_rdata} !== {2'b10, rom(32'hBFC0_0004)}) begin n_err++; $display("FAIL conflict_inst_resp: got %b %h want 10 %h", rv, bus.inst_rdata, rom(32'hBFC0_0004)); end
    endtask

    task automatic test_starvation();
        logic [5:0] inst_pat;
        int data_grants;
        inst_pat = 6'b010000;
        data_grants = 0;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            drive_cycle(1'b1, 32'hBFC0_0100 + 32'(c * 4), 1'b1, 4'h0, 32'h8000_0100 + 32'(c * 4), 32'h0);
            n_cmp++; if ({bus.inst_gnt, bus.data_gnt} !== {inst_pat[c], ~inst_pat[c]}) begin n_err++; $display("FAIL starve_gnt[%0d]: got %b want %b", c, {bus.inst_gnt, bus.data_gnt}, {inst_pat[c], ~inst_pat[c]}); end
            if (c == 4) begin
                n_cmp++; if (starve_cnt_dbg !== 4'(LIMIT)) begin n_err++; $display("FAIL starve_cnt: got %0d want %0d", starve_cnt_dbg, LIMIT); end
            end
            if (bus.data_gnt) data_grants++;
        end
        n_cmp++; if (data_grants != 5) begin n_err++; $display("FAIL starve_total: got %0d want 5", data_grants); end
        drive_cycle(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic test_store();
        do_reset();
        drive_cycle(1'b0, 32'h0, 1'b1, 4'b0011, 32'h8000_0020, 32'h0000_BEEF);
        n_cmp++; if (ctl !== 4'b0110) begin n_err++; $display("FAIL store_ctl: got %b want 0110", ctl); end
        n_cmp++; if (sram_cmd !== {4'b0011, 32'h8000_0020, 32'h0000_BEEF}) begin n_err++; $display("FAIL store_sram: got %h want %h", sram_cmd, {4'b0011, 32'h8000_0020, 32'h0000_BEEF}); end
        drive_cycle(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        n_cmp++; if ({rv, bus.sram_wen} !== 6'b0) begin n_err++; $display("FAIL store_after: got %b %b want 00 0000", rv, bus.sram_wen); end
        n_cmp++; if (state_dbg !== IDLE) begin n_err++; $display("FAIL store_state: got %0d want IDLE", state_dbg); end
    endtask

    task automatic test_reset_inflight();
        do_reset();
        drive_cycle(1'b0, 32'h0, 1'b1, 4'h0, 32'h8000_0040, 32'h0);
        n_cmp++; if (ctl !== 4'b0110) begin n_err++; $display("FAIL inflight_gnt: got %b want 0110", ctl); end
        #2 rst = 1'b0;
        #1;
        n_cmp++; if ({ctl, sram_cmd} !== 72'h0) begin n_err++; $display("FAIL inflight_async: got %b %h want 0", ctl, sram_cmd); end
        @(posedge clk); #1;
        n_cmp++; if ({rv, bus.data_rdata} !== 34'h0) begin n_err++; $display("FAIL inflight_rvalid: got %b %h want 0", rv, bus.data_rdata); end
        @(negedge clk);
        rst = 1'b1;
        set_req(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            n_cmp++; if (rv !== 2'b00) begin n_err++; $display("FAIL inflight_post[%0d]: got %b want 00", c, rv); end
        end
        // response already visible, then reset mid-cycle
        drive_cycle(1'b0, 32'h0, 1'b1, 4'h0, 32'h8000_0044, 32'h0);
        drive_cycle(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        n_cmp++; if ({rv, bus.data_rdata} !== {2'b01, rom(32'h8000_0044)}) begin n_err++; $display("FAIL midreset_pre: got %b %h want 01 %h", rv, bus.data_rdata, rom(32'h8000_0044)); end
        #1 rst = 1'b0;
        #1;
        n_cmp++; if ({rv, bus.data_rdata} !== 34'h0) begin n_err++; $display("FAIL midreset_async: got %b %h want 0", rv, bus.data_rdata); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk); #1;
        n_cmp++; if (rv !== 2'b00) begin n_err++; $display("FAIL midreset_post: got %b want 00", rv); end
    endtask

    task automatic test_alternating();
        logic [31:0] prev_addr;
        logic        prev_inst;
        logic [31:0] a;
        do_reset();
        prev_addr = 32'h0;
        prev_inst = 1'b0;
        for (int c = 0; c < 9; c++) begin
            if (c == 8) begin
                drive_cycle(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
            end else if (c % 2 == 0) begin
                a = 32'hBFC0_0200 + 32'(c * 4);
                drive_cycle(1'b1, a, 1'b0, 4'h0, 32'h0, 32'h0);
                n_cmp++; if (ctl !== 4'b1010) begin n_err++; $display("FAIL alt_gnt[%0d]: got %b want 1010", c, ctl); end
            end else begin
                a = 32'h8000_0200 + 32'(c * 4);
                drive_cycle(1'b0, 32'h0, 1'b1, 4'h0, a, 32'h0);
                n_cmp++; if (ctl !== 4'b0110) begin n_err++; $display("FAIL alt_gnt[%0d]: got %b want 0110", c, ctl); end
            end
            if (c > 0) begin
                n_cmp++;
                if ({rv, bus.inst_rdata, bus.data_rdata} !== (prev_inst ? {2'b10, rom(prev_addr), 32'h0} : {2'b01, 32'h0, rom(prev_addr)})) begin
                    n_err++; $display("FAIL alt_resp[%0d]: got %b %h %h want inst=%b %h", c, rv, bus.inst_rdata, bus.data_rdata, prev_inst, rom(prev_addr));
                end
            end
            prev_addr = a;
            prev_inst = (c % 2 == 0);
        end
    endtask

    task automatic test_random();
        logic [33:0] exp_q[$];
        logic [33:0] cur;
        logic [67:0] ecmd;
        logic        ireq, dreq, eig, edg, estall;
        logic [31:0] iaddr, daddr, dwdata;
        logic [3:0]  dwen;
        int          waits;
        do_reset();
        exp_q.delete();
        exp_q.push_back(34'h0);
        waits = 0;
        ireq = 1'b0; dreq = 1'b0;
        iaddr = 32'h0; daddr = 32'h0; dwdata = 32'h0; dwen = 4'h0;
        for (int n = 0; n < 500; n++) begin
            if (!ireq) begin
                ireq  = ($urandom_range(0, 99) < 60);
                iaddr = $urandom & 32'hFFFF_FFFC;
            end
            if (!dreq) begin
                dreq   = ($urandom_range(0, 99) < 65);
                daddr  = $urandom;
                dwdata = $urandom;
                dwen   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            end
            drive_cycle(ireq, iaddr, dreq, dwen, daddr, dwdata);

            // Data first, unless the fetch has already been overtaken LIMIT times.
            edg = dreq && !(ireq && (waits >= int'(LIMIT)));
            eig = ireq && !edg;
            cur = exp_q.pop_front();
            estall = (ireq && !eig) || (dreq && !edg) || (cur[32] && dreq && !edg);
            ecmd = edg ? {dwen, daddr, dwdata} : (eig ? {4'h0, iaddr, 32'h0} : 68'h0);

            n_cmp++; if (ctl !== {eig, edg, eig | edg, estall}) begin n_err++; $display("FAIL rand_ctl[%0d]: got %b want %b", n, ctl, {eig, edg, eig | edg, estall}); end
            n_cmp++; if (sram_cmd !== ecmd) begin n_err++; $display("FAIL rand_sram[%0d]: got %h want %h", n, sram_cmd, ecmd); end
            n_cmp++;
            if ({rv, bus.inst_rdata, bus.data_rdata} !== {cur[33:32], cur[33] ? cur[31:0] : 32'h0, cur[32] ? cur[31:0] : 32'h0}) begin
                n_err++; $display("FAIL rand_resp[%0d]: got %b %h %h want %b %h", n, rv, bus.inst_rdata, bus.data_rdata, cur[33:32], cur[31:0]);
            end

            exp_q.push_back(eig ? {2'b10, rom(iaddr)} : ((edg && dwen == 4'h0) ? {2'b01, rom(daddr)} : 34'h0));
            waits = (ireq && edg) ? waits + 1 : 0;
            if (eig) ireq = 1'b0;
            if (edg) dreq = 1'b0;
        end
        drive_cycle(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        set_req(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        test_reset();
        test_inst_fetch();
        test_conflict();
        test_starvation();
        test_store();
        test_reset_inflight();
        test_alternating();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
